// File: rtl/mem_fill_pkg.sv
// Shared types for the memory fill engine: FSM states and fill patterns.
package mem_fill_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        M_IDENTITY = 2'd0,
        M_CONST    = 2'd1,
        M_INCR     = 2'd2,
        M_RSVD     = 2'd3
    } mode_e;

endpackage

// File: rtl/mem_fill_datagen.sv
// Combinational fill-pattern generator.
module mem_fill_datagen
    import mem_fill_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  mode_e             mode,
    input  logic [ADDR_W-1:0] counter,
    input  logic [ADDR_W-1:0] base,
    input  logic [DATA_W-1:0] fill_value,
    output logic [DATA_W-1:0] data
);

    localparam int W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;

    logic [W-1:0] w_off;

    // counter never drops below base while writing, so the offset is unsigned
    assign w_off = W'(counter) - W'(base);

    always_comb begin
        data = fill_value;
        case (mode)
            M_IDENTITY: data = DATA_W'(counter);
            M_INCR:     data = fill_value + DATA_W'(w_off);
            default:    data = fill_value;
        endcase
    end

endmodule

// File: rtl/mem_fill_fsm.sv
// Memory fill engine: writes a pattern over [base_addr, last_addr]
// with a wr_ready handshake, abort, and range-error detection.
module mem_fill_fsm
    import mem_fill_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] last_addr,
    input  logic [DATA_W-1:0] fill_value,
    input  logic              wr_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              finish,
    output logic              range_err
);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_last;
    logic [DATA_W-1:0] r_fill;
    mode_e             r_mode;
    logic [DATA_W-1:0] w_data;
    logic              w_is_write;

    mem_fill_datagen #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_datagen (
        .mode       (r_mode),
        .counter    (r_cnt),
        .base       (r_base),
        .fill_value (r_fill),
        .data       (w_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = (last_addr < base_addr) ? S_DONE : S_WRITE;
                end
            end
            S_WRITE: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (wr_ready && (r_cnt == r_last)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Counter holds on the final word so last_addr at full scale never wraps
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_base <= '0;
            r_last <= '0;
            r_fill <= '0;
            r_mode <= M_IDENTITY;
        end else if ((r_state == S_IDLE) && start) begin
            r_cnt  <= base_addr;
            r_base <= base_addr;
            r_last <= last_addr;
            r_fill <= fill_value;
            r_mode <= mode_e'(mode);
        end else if ((r_state == S_WRITE) && !abort && wr_ready
                     && (r_cnt != r_last)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_is_write = (r_state == S_WRITE);
    assign wr_en      = w_is_write;
    assign busy       = w_is_write || (r_state == S_DONE);
    assign finish     = (r_state == S_DONE);
    assign range_err  = (r_state == S_DONE) && (r_last < r_base);
    assign mem_addr   = w_is_write ? r_cnt : '0;
    assign wr_data    = w_is_write ? w_data : '0;

endmodule

// File: tb/tb_mem_fill_fsm.sv
// Self-checking bench for mem_fill_fsm: vector table, corner sequences,
// and randomized fills against a transaction-level reference model.
module tb_mem_fill_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [1:0] mode;
    logic [7:0] base_addr;
    logic [7:0] last_addr;
    logic [7:0] fill_value;
    logic       wr_ready;
    logic       wr_en;
    logic [7:0] mem_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       finish;
    logic       range_err;

    int checks = 0;
    int failures = 0;

    logic [7:0] log_a[$];
    logic [7:0] log_d[$];

    typedef struct {
        logic [1:0] mode;
        logic [7:0] base;
        logic [7:0] last;
        logic [7:0] fill;
        int         stall_pct;
        int         stall_idx;
        int         stall_len;
        int         abort_at;
        int         exp_wr;
        logic       exp_rerr;
    } vec_t;

    mem_fill_fsm #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .mode       (mode),
        .base_addr  (base_addr),
        .last_addr  (last_addr),
        .fill_value (fill_value),
        .wr_ready   (wr_ready),
        .wr_en      (wr_en),
        .mem_addr   (mem_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .finish     (finish),
        .range_err  (range_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_data(input vec_t v, input int idx);
        logic [7:0] a;
        a = v.base + 8'(idx);
        case (v.mode)
            2'd0:    return a;
            2'd2:    return v.fill + 8'(idx);
            default: return v.fill;
        endcase
    endfunction

    task automatic scramble_cfg();
        mode       = 2'($urandom);
        base_addr  = 8'($urandom);
        last_addr  = 8'($urandom);
        fill_value = 8'($urandom);
    endtask

    task automatic run_fill(input vec_t v, input string nm);
        int   n;
        int   idx;
        int   cyc;
        int   stalls;
        bit   rerr;
        bit   rdy;
        bit   aborted;
        rerr = (v.last < v.base);
        n = rerr ? 0 : int'(v.last) - int'(v.base) + 1;
        log_a.delete();
        log_d.delete();
        idx = 0;
        cyc = 0;
        stalls = 0;
        aborted = 0;
        @(negedge clk);
        chk({nm, "_idle_pre"}, {wr_en, busy, finish, range_err}, 4'h0);
        mode       = v.mode;
        base_addr  = v.base;
        last_addr  = v.last;
        fill_value = v.fill;
        start      = 1'b1;
        abort      = 1'($urandom_range(0, 1));
        wr_ready   = 1'($urandom_range(0, 1));
        @(negedge clk);
        abort = 1'b0;
        while (idx < n && !aborted) begin
            cyc++;
            if (cyc > 5000) begin
                chk({nm, "_timeout"}, 32'(cyc), 32'(n));
                break;
            end
            chk({nm, "_wr_en"}, {wr_en, busy, finish, range_err}, 4'b1100);
            chk({nm, "_addr"}, mem_addr, v.base + 8'(idx));
            chk({nm, "_data"}, wr_data, model_data(v, idx));
            if (idx == v.stall_idx && stalls < v.stall_len) begin
                rdy = 1'b0;
                stalls++;
            end else begin
                rdy = ($urandom_range(0, 99) >= v.stall_pct);
            end
            wr_ready = rdy;
            abort = ((cyc - 1) == v.abort_at);
            start = 1'($urandom_range(0, 1));
            scramble_cfg();
            if (rdy) begin
                log_a.push_back(mem_addr);
                log_d.push_back(wr_data);
                idx++;
            end
            if (abort) aborted = 1;
            @(negedge clk);
        end
        start = 1'b0;
        abort = 1'b0;
        if (aborted) begin
            chk({nm, "_abort_idle"}, {wr_en, busy, finish, range_err}, 4'h0);
        end else begin
            chk({nm, "_done"}, {wr_en, busy, finish, range_err},
                {3'b011, rerr});
            if (v.stall_pct == 0 && v.stall_len == 0)
                chk({nm, "_cycles"}, 32'(cyc + 1), 32'(n + 1));
            abort = 1'($urandom_range(0, 1));
            @(negedge clk);
            abort = 1'b0;
            chk({nm, "_idle_post"}, {wr_en, busy, finish, range_err}, 4'h0);
        end
        if (v.exp_wr >= 0)
            chk({nm, "_nwrites"}, 32'(log_a.size()), 32'(v.exp_wr));
    endtask

    initial begin
        vec_t       tbl[8];
        vec_t       rv;
        logic [15:0] incr_exp[4];
        int         guard;

        tbl[0] = '{2'd0, 8'h00, 8'hFF, 8'h00, 0,  -1, 0, -1, 256, 1'b0};
        tbl[1] = '{2'd2, 8'h10, 8'h13, 8'hFE, 0,  -1, 0, -1, 4,   1'b0};
        tbl[2] = '{2'd1, 8'h20, 8'h22, 8'hA5, 0,  1,  3, -1, 3,   1'b0};
        tbl[3] = '{2'd0, 8'h40, 8'h3F, 8'h00, 0,  -1, 0, -1, 0,   1'b1};
        tbl[4] = '{2'd0, 8'h00, 8'h0F, 8'h00, 0,  -1, 0, 2,  3,   1'b0};
        tbl[5] = '{2'd0, 8'h30, 8'h33, 8'h00, 0,  -1, 0, -1, 4,   1'b0};
        tbl[6] = '{2'd3, 8'hFC, 8'hFF, 8'h3C, 30, -1, 0, -1, 4,   1'b0};
        tbl[7] = '{2'd2, 8'h7F, 8'h7F, 8'h12, 0,  -1, 0, -1, 1,   1'b0};
        incr_exp = '{16'h10FE, 16'h11FF, 16'h1200, 16'h1301};

        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        wr_ready = 1'b0;
        scramble_cfg();
        repeat (2) @(negedge clk);
        chk("reset_outputs",
            {wr_en, busy, finish, range_err, mem_addr, wr_data}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_outputs",
            {wr_en, busy, finish, range_err, mem_addr, wr_data}, 32'h0);

        for (int i = 0; i < 8; i++) begin
            run_fill(tbl[i], $sformatf("vec%0d", i));
            if (i == 1) begin
                for (int k = 0; k < 4 && k < log_a.size(); k++)
                    chk($sformatf("incr_word%0d", k),
                        {log_a[k], log_d[k]}, incr_exp[k]);
            end
        end

        // Reset mid-fill with start held high throughout
        @(negedge clk);
        mode = 2'd0;
        base_addr = 8'h00;
        last_addr = 8'h0F;
        fill_value = 8'h00;
        wr_ready = 1'b1;
        start = 1'b1;
        guard = 0;
        @(negedge clk);
        while (!(wr_en && mem_addr == 8'h05) && guard < 50) begin
            guard++;
            @(negedge clk);
        end
        chk("rst_mid_reach_addr5", {wr_en, mem_addr}, {1'b1, 8'h05});
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_outputs",
            {wr_en, busy, finish, range_err, mem_addr, wr_data}, 32'h0);
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_idle",
            {wr_en, busy, finish, range_err, mem_addr, wr_data}, 32'h0);

        for (int r = 0; r < 30; r++) begin
            rv.mode = 2'($urandom);
            rv.base = 8'($urandom);
            rv.last = rv.base + 8'($urandom_range(0, 10));
            if ($urandom_range(0, 7) == 0) rv.last = rv.base - 8'($urandom_range(1, 5));
            rv.fill = 8'($urandom);
            rv.stall_pct = $urandom_range(0, 50);
            rv.stall_idx = -1;
            rv.stall_len = 0;
            rv.abort_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 12) : -1;
            rv.exp_wr = -1;
            rv.exp_rerr = 1'b0;
            run_fill(rv, $sformatf("rnd%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
